// File: rtl/pci_initiator_arbiter.sv
// pci_initiator_arbiter: round-robin sharing of one PCI core initiator port among NUM_REQ requesters.
// Define PCI_ARB_RETRY_LIMIT_EN to end a transfer with an error on the 16th consecutive retry.
module pci_initiator_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 8
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       dir_i,
    input  logic [NUM_REQ*30-1:0]    addr_i,
    input  logic [NUM_REQ*LEN_W-1:0] len_i,
    input  logic [NUM_REQ*32-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       beat_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     err_o,
    output logic [31:0]              rdata_o,
    input  logic [31:0]              adio_out,
    output logic [31:0]              adio_in,
    output logic                     adio_oe,
    input  logic                     m_data,
    input  logic                     m_data_vld,
    input  logic                     m_addr_n,
    input  logic [39:0]              csr,
    output logic                     request,
    output logic                     requesthold,
    output logic                     complete,
    output logic                     m_ready,
    output logic                     m_wrdn,
    output logic [3:0]               m_cbe
);
    localparam int PW = (NUM_REQ > 2) ? 2 : 1;
    typedef enum logic [2:0] {IDLE, REQ, XFER, RTY, DONE} state_t;
    state_t               r_state;
    logic [PW-1:0]        r_ptr, r_idx, w_pick, w_off;
    logic [PW:0]          w_sum;
    logic [2*NUM_REQ-1:0] w_rot;
    logic [NUM_REQ-1:0]   r_gnt, r_beat, r_done;
    logic                 r_dir, r_err, r_request, r_complete, r_m_ready;
    logic                 r_fatal, r_retry, r_mdata_q;
    logic [29:0]          r_addr;
    logic [31:0]          r_rdata;
    logic [LEN_W-1:0]     w_len_raw;
    logic [LEN_W:0]       r_remain, w_len, w_rem_dec;
    logic                 w_fell, w_beat, w_addr_ph, w_wr_ph, w_lim, w_unused;
`ifdef PCI_ARB_RETRY_LIMIT_EN
    logic [3:0]           r_rcnt;
    assign w_lim = (r_rcnt == 4'hF);
`else
    assign w_lim = 1'b0;
`endif
    // rotate requests so the pointer sits at bit 0, then take the lowest set bit
    always_comb begin
        w_rot = {req_i, req_i} >> r_ptr;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (w_rot[k]) w_off = PW'(k);
        w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
        w_pick = (w_sum >= (PW+1)'(NUM_REQ)) ? PW'(w_sum - (PW+1)'(NUM_REQ)) : w_sum[PW-1:0];
    end
    assign w_len_raw = len_i[w_pick*LEN_W +: LEN_W];
    assign w_len     = (w_len_raw == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, w_len_raw};
    assign w_fell    = r_mdata_q & ~m_data;
    assign w_beat    = (r_state == XFER) & m_data_vld;
    assign w_rem_dec = r_remain - {{LEN_W{1'b0}}, w_beat && (r_remain != '0)};
    assign w_addr_ph = (|r_gnt) & ~m_addr_n;
    assign w_wr_ph   = (r_state == XFER) & r_dir & m_data;
    assign m_cbe       = w_addr_ph ? {3'b011, r_dir} : 4'b0000;
    assign adio_in     = w_addr_ph ? {r_addr, 2'b00} : w_wr_ph ? wdata_i[r_idx*32 +: 32] : 32'd0;
    assign adio_oe     = w_addr_ph | w_wr_ph;
    assign m_wrdn      = r_dir & (|r_gnt);
    assign gnt_o       = r_gnt;
    assign beat_o      = r_beat;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign request     = r_request;
    assign requesthold = 1'b0;
    assign complete    = r_complete;
    assign m_ready     = r_m_ready;
    assign w_unused    = ^{csr[37], csr[35:0], r_retry};
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_gnt      <= '0;
            r_beat     <= '0;
            r_done     <= '0;
            r_dir      <= 1'b0;
            r_err      <= 1'b0;
            r_request  <= 1'b0;
            r_complete <= 1'b0;
            r_m_ready  <= 1'b0;
            r_fatal    <= 1'b0;
            r_retry    <= 1'b0;
            r_mdata_q  <= 1'b0;
            r_addr     <= '0;
            r_rdata    <= '0;
            r_remain   <= '0;
`ifdef PCI_ARB_RETRY_LIMIT_EN
            r_rcnt     <= '0;
`endif
        end else begin
            r_m_ready <= 1'b1;
            r_mdata_q <= m_data;
            if (!m_addr_n) begin
                r_fatal <= 1'b0;
                r_retry <= 1'b0;
            end else if (m_data) begin
                r_fatal <= csr[39] | csr[38];
                r_retry <= csr[36];
            end
            r_beat <= w_beat ? r_gnt : '0;
            if (w_beat && !r_dir) r_rdata <= adio_out;
            r_request <= 1'b0;
            r_done    <= '0;
            r_err     <= 1'b0;
            case (r_state)
                IDLE: if (|req_i) begin
                    r_state    <= REQ;
                    r_gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                    r_idx      <= w_pick;
                    r_dir      <= dir_i[w_pick];
                    r_addr     <= addr_i[w_pick*30 +: 30];
                    r_remain   <= w_len;
                    r_request  <= 1'b1;
                    r_complete <= (w_len <= (LEN_W+1)'(1));
`ifdef PCI_ARB_RETRY_LIMIT_EN
                    r_rcnt     <= '0;
`endif
                end
                REQ: r_state <= XFER;
                XFER: begin
                    if (w_beat) begin
                        r_remain <= w_rem_dec;
                        r_addr   <= r_addr + 30'd1;
                    end
                    // a beat in the same cycle as the falling edge is counted before deciding
                    if (w_fell && (r_fatal || w_rem_dec == '0 || w_lim)) begin
                        r_state    <= DONE;
                        r_done     <= r_gnt;
                        r_err      <= r_fatal | (w_rem_dec != '0);
                        r_complete <= 1'b0;
                    end else if (w_fell) begin
                        r_state    <= RTY;
                        r_complete <= 1'b0;
`ifdef PCI_ARB_RETRY_LIMIT_EN
                        r_rcnt     <= r_rcnt + 4'd1;
`endif
                    end else begin
                        r_complete <= (w_rem_dec <= (LEN_W+1)'(1));
                    end
                end
                RTY: begin
                    r_state    <= REQ;
                    r_request  <= 1'b1;
                    r_complete <= (r_remain <= (LEN_W+1)'(1));
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_gnt      <= '0;
                    r_complete <= 1'b0;
                    r_ptr      <= (r_idx == PW'(NUM_REQ - 1)) ? '0 : r_idx + PW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pci_initiator_arbiter.sv
// tb_pci_initiator_arbiter: directed checks of arbitration, core handshake, retry, fatal and reset.
module tb_pci_initiator_arbiter;
    logic         CLK = 1'b0;
    logic         reset_n;
    logic [3:0]   req_i, dir_i;
    logic [119:0] addr_i;
    logic [31:0]  len_i;
    logic [127:0] wdata_i;
    logic [3:0]   gnt_o, beat_o, done_o, m_cbe;
    logic         err_o, adio_oe, request, requesthold, complete, m_ready, m_wrdn;
    logic [31:0]  rdata_o, adio_out, adio_in;
    logic         m_data, m_data_vld, m_addr_n;
    logic [39:0]  csr;
    int           n_chk = 0;
    int           n_err = 0;

    pci_initiator_arbiter #(.NUM_REQ(4), .LEN_W(8)) dut (
        .CLK(CLK), .reset_n(reset_n), .req_i(req_i), .dir_i(dir_i), .addr_i(addr_i),
        .len_i(len_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .beat_o(beat_o), .done_o(done_o),
        .err_o(err_o), .rdata_o(rdata_o), .adio_out(adio_out), .adio_in(adio_in),
        .adio_oe(adio_oe), .m_data(m_data), .m_data_vld(m_data_vld), .m_addr_n(m_addr_n),
        .csr(csr), .request(request), .requesthold(requesthold), .complete(complete),
        .m_ready(m_ready), .m_wrdn(m_wrdn), .m_cbe(m_cbe)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ch(input int c, input logic d, input logic [29:0] a, input logic [7:0] l,
                          input logic [31:0] wd);
        dir_i[c]           = d;
        addr_i[c*30 +: 30] = a;
        len_i[c*8 +: 8]    = l;
        wdata_i[c*32 +: 32] = wd;
    endtask

    // core side of one request/address/data sequence; nb beats, ecsr presented on the last beat
    task automatic core_burst(input logic [3:0] g, input logic [31:0] a, input logic [3:0] cbe,
                              input logic cmpl, input int nb, input logic [39:0] ecsr,
                              input logic [31:0] rb, input logic [31:0] wd);
        int n = 0;
        while (request !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("request", request, 1);
        check("gnt", gnt_o, g);
        tick();
        m_addr_n = 1'b0;
        #1;
        check("adio_addr", adio_in, a);
        check("m_cbe_addr", m_cbe, cbe);
        check("adio_oe_addr", adio_oe, 1);
        check("m_wrdn", m_wrdn, cbe[0]);
        check("complete", complete, cmpl);
        for (int i = 0; i < nb; i++) begin
            tick();
            m_addr_n   = 1'b1;
            m_data     = 1'b1;
            m_data_vld = 1'b1;
            adio_out   = rb + i;
            csr        = (i == nb - 1) ? ecsr : 40'd0;
            #1;
            if (i == 0) check("m_cbe_data", m_cbe, 0);
            if (cbe[0]) check("wdata", adio_in, wd);
            if (i > 0) begin
                check("beat", beat_o, g);
                if (!cbe[0]) check("rdata", rdata_o, rb + i - 1);
            end
        end
        tick();
        m_data     = 1'b0;
        m_data_vld = 1'b0;
        csr        = 40'd0;
        #1;
        check("beat_last", beat_o, g);
        if (!cbe[0]) check("rdata_last", rdata_o, rb + nb - 1);
    endtask

    task automatic wait_done(input logic [3:0] g, input logic e);
        int n = 0;
        do begin
            tick();
            n++;
        end while (done_o === 4'd0 && n < 10);
        check("done", done_o, g);
        check("err", err_o, e);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        req_i = '0; dir_i = '0; addr_i = '0; len_i = '0; wdata_i = '0;
        adio_out = '0; m_data = 1'b0; m_data_vld = 1'b0; m_addr_n = 1'b1; csr = '0;
        tick();
        tick();
        check("rst_outs", {gnt_o, beat_o, done_o, err_o, request, complete, m_ready, m_wrdn, adio_oe, requesthold}, 0);
        check("rst_adio", adio_in, 0);
        check("rst_cbe", m_cbe, 0);
        reset_n = 1'b1;
        check("m_ready_pre", m_ready, 0);
        tick();
        check("m_ready", m_ready, 1);

        // ch0 single write
        set_ch(0, 1'b1, 30'h400, 8'd1, 32'hA5A5A5A5);
        req_i = 4'b0001;
        core_burst(4'b0001, 32'h1000, 4'b0111, 1'b1, 1, 40'd0, 0, 32'hA5A5A5A5);
        wait_done(4'b0001, 1'b0);
        req_i = 4'b0000;
        tick();
        check("gnt_drop", gnt_o, 0);

        // ch1 read of four beats
        set_ch(1, 1'b0, 30'h800, 8'd4, 0);
        req_i = 4'b0010;
        core_burst(4'b0010, 32'h2000, 4'b0110, 1'b0, 4, 40'd0, 1, 0);
        wait_done(4'b0010, 1'b0);
        req_i = 4'b0000;

        // ch3 write of 8, retried after 3 beats, resumes at 0x300C
        set_ch(3, 1'b1, 30'hC00, 8'd8, 32'hDEADBEEF);
        req_i = 4'b1000;
        core_burst(4'b1000, 32'h3000, 4'b0111, 1'b0, 3, 40'h10_0000_0000, 0, 32'hDEADBEEF);
        tick();
        check("rty_nodone", done_o, 0);
        core_burst(4'b1000, 32'h300C, 4'b0111, 1'b0, 5, 40'd0, 0, 32'hDEADBEEF);
        wait_done(4'b1000, 1'b0);
        req_i = 4'b0000;
        tick();
        check("done_pulse", done_o, 0);

        // pointer 0: ch0 and ch2 together, ch0 keeps requesting
        set_ch(0, 1'b0, 30'h040, 8'd1, 0);
        set_ch(2, 1'b0, 30'h080, 8'd1, 0);
        req_i = 4'b0101;
        core_burst(4'b0001, 32'h100, 4'b0110, 1'b1, 1, 40'd0, 32'h11, 0);
        wait_done(4'b0001, 1'b0);
        core_burst(4'b0100, 32'h200, 4'b0110, 1'b1, 1, 40'd0, 32'h22, 0);
        wait_done(4'b0100, 1'b0);
        req_i = 4'b0001;
        core_burst(4'b0001, 32'h100, 4'b0110, 1'b1, 1, 40'd0, 32'h33, 0);
        wait_done(4'b0001, 1'b0);
        req_i = 4'b0000;

        // fatal abort on beat 2 of ch1, ch2 served next
        set_ch(1, 1'b0, 30'h1000, 8'd4, 0);
        req_i = 4'b0110;
        core_burst(4'b0010, 32'h4000, 4'b0110, 1'b0, 2, 40'h80_0000_0000, 32'h40, 0);
        wait_done(4'b0010, 1'b1);
        req_i = 4'b0100;
        core_burst(4'b0100, 32'h200, 4'b0110, 1'b1, 1, 40'd0, 32'h50, 0);
        wait_done(4'b0100, 1'b0);
        req_i = 4'b0000;

        // reset in the middle of a ch3 write
        set_ch(3, 1'b1, 30'h1400, 8'd4, 32'h55AA55AA);
        req_i = 4'b1000;
        n = 0;
        while (request !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("mid_req", gnt_o, 4'b1000);
        tick();
        m_addr_n = 1'b0;
        tick();
        m_addr_n = 1'b1; m_data = 1'b1; m_data_vld = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_outs", {gnt_o, request, adio_oe, beat_o, done_o, m_ready}, 0);
        m_data = 1'b0; m_data_vld = 1'b0; req_i = 4'b0000;
        tick();
        tick();
        check("mid_rst_done", done_o, 0);
        reset_n = 1'b1;
        tick();
        check("mid_m_ready", m_ready, 1);
        tick();
        check("mid_idle", {gnt_o, done_o, request}, 0);

`ifdef PCI_ARB_RETRY_LIMIT_EN
        // target retries forever: 16th retry ends with an error
        set_ch(0, 1'b0, 30'h2000, 8'd0, 0);
        req_i = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            core_burst(4'b0001, 32'h8000 + 32'(k * 4), 4'b0110, 1'b0, 1, 40'h10_0000_0000, 32'(k), 0);
            if (k < 15) begin
                tick();
                check("lim_rty", done_o, 0);
            end
        end
        wait_done(4'b0001, 1'b1);
        req_i = 4'b0000;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/pci_initiator_arbiter.md
Name: pci_initiator_arbiter

Overview:
- Shares the single PCI core initiator (user-side master) interface among NUM_REQ local requesters, e.g. DMA channels.
- Round-robin arbitration picks one requester. The block then sequences the core handshake (request, m_cbe, m_wrdn, complete) and drives the address phase.
- Counts data beats, resumes retried or disconnected bursts from the next address, and reports done/error per requester.
- Sits between the DMA engines and the PCI core user interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..4).
- LEN_W, 8, burst length field width in dwords; length 0 means 2**LEN_W beats.

Ports:
- CLK input 1: core clock; all logic on rising edge.
- reset_n input 1: asynchronous, active-low reset.
- req_i input NUM_REQ: per-requester transfer request; held high until done_o.
- dir_i input NUM_REQ: 1 = write (memory write), 0 = read.
- addr_i input NUM_REQ*30: dword start address [31:2] per requester.
- len_i input NUM_REQ*LEN_W: beats per requester.
- wdata_i input NUM_REQ*32: write data per requester.
- gnt_o output NUM_REQ: one-hot grant for the current owner.
- beat_o output NUM_REQ: one-hot data strobe. Write: wdata consumed. Read: rdata_o valid.
- done_o output NUM_REQ: one-cycle pulse when the owner's transfer ends.
- err_o output 1: qualifies done_o; set on fatal abort.
- rdata_o output 32: registered copy of adio_out.
- adio_out input 32: core read data.
- adio_in output 32: address or write data to core.
- adio_oe output 1: adio_in valid (address phase, or write data phase).
- m_data, m_data_vld, m_addr_n input 1 each: core status.
- csr input 40: core status; bit 36 retry, bits 39/38 fatal.
- request, requesthold, complete, m_ready, m_wrdn output 1 each: core controls.
- m_cbe output 4: command/byte enables.

Behaviour:
- Reset values: all outputs 0, except adio_in 0 and m_cbe 0. State IDLE; round-robin pointer 0.
- m_ready rises to 1 on the first clock after reset release. requesthold is always 0.
- fatal/retry flags:
  - Cleared while m_addr_n is low.
  - Loaded while m_data is high: fatal = csr[39]|csr[38], retry = csr[36].
  - m_data_fell = m_data registered high and now low.
- States and transitions:
  - IDLE: if any req_i is set, pick the first set bit at or after the pointer. Latch grant, dir, addr, remain = len, then go to REQ; gnt_o asserts in the same cycle as REQ.
  - REQ: request=1 for exactly one cycle, then XFER.
  - XFER: on each m_data_vld, pulse beat_o[grant], decrement remain, increment addr (wraps at 2**30). On m_data_fell:
    - fatal → DONE with err;
    - else remain==0 → DONE;
    - else (retry or target disconnect) → RTY.
  - RTY: one idle cycle, then REQ, re-requesting from the current addr with the current remain.
  - DONE: pulse done_o[grant] (err_o if fatal). Drop gnt_o, set pointer = grant+1 mod NUM_REQ, go to IDLE. The next arbitration happens one cycle later.
- complete: registered; 1 in REQ/XFER when remain ≤ 1 (the next accepted beat is last); 0 in all other states.
- Address and data outputs:
  - m_addr_n low: m_cbe = {3'b011, dir}, adio_in = {addr, 2'b00}, adio_oe = 1.
  - Otherwise m_cbe = 4'b0000.
  - Write data phase (XFER & dir & m_data): adio_in = wdata_i[grant], adio_oe = 1.
- m_wrdn = latched dir while granted, else 0.
- rdata_o: loads adio_out on m_data_vld in a read; valid in the cycle beat_o pulses.
- Requester dropping req_i mid-transfer: ignored; the transfer completes.
- Requests arriving during DONE: wait for IDLE.
- Simultaneous m_data_vld and m_data_fell: the beat counts before the exit decision.
- reset_n low mid-transfer: immediate return to IDLE, all outputs to reset values, no done_o.

Optional Feature:
- Macro: PCI_ARB_RETRY_LIMIT_EN.
- Defined:
  - A 4-bit retry counter, cleared on grant, increments on each entry to RTY.
  - The 16th consecutive retry goes to DONE with err_o=1 instead of RTY.
- Undefined: retries are unlimited and no counter exists.

Test Plan:
- Ch0 single write, addr 0x1000, len 1, wdata 0xA5A5A5A5 → one request pulse; address phase adio_in=0x00001000, m_cbe=4'b0111; one beat_o[0]; complete high before the beat; done_o[0] with err_o=0.
- Ch1 read len 4 at 0x2000, core returns 1,2,3,4 → beat_o[1]×4 with rdata_o 1..4; m_cbe=4'b0110 at address; done_o[1].
- Ch0 and ch2 request together, pointer 0 → ch0 served first, then ch2. Ch0 re-requests → ch2's successor ch3/ch0 order respected; no starvation.
- Write len 8 at 0x3000, retry (csr[36]) after 3 beats → RTY, a second request, address phase 0x0000300C; 5 more beats; a single done_o.
- Fatal (csr[39]) during beat 2 → done_o with err_o=1, return to IDLE, next requester granted.
- Reset_n low during XFER → gnt_o/request/adio_oe 0 next edge, no done_o. With PCI_ARB_RETRY_LIMIT_EN, a target always retrying → done+err after 16 retries.
